// File: rtl/maze_mem_arbiter_pkg.sv
// Shared types and constants for the maze memory arbiter.
//   COORD_W / DATA_W : default coordinate and cell-data widths (16x16 maze, 1-bit cells)
//   arb_state_t      : arbiter FSM state (exposed on the top-level debug port)
//   mem_cmd_t        : one registered memory command as captured at grant time
//   port_onehot      : turns a port number into its one-hot ack pattern
package maze_mem_arbiter_pkg;

  localparam int COORD_W = 4;
  localparam int DATA_W  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               rd;
    logic               wr;
    logic [DATA_W-1:0]  wdata;
    logic               lock;
  } mem_cmd_t;

  function automatic logic [1:0] port_onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/maze_mem_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the maze memory.
//   rq_*  : per-port request side (index 0 = solver, index 1 = secondary agent)
//   mem_* : single-port maze memory side (mem_dout is a combinational read)
//
// Handshake: a requester raises rq_req[p] with its command fields and holds
// all of them stable until it sees the one-cycle rq_ack[p] pulse; rq_rdata is
// meaningful only in that ack cycle. Lowering rq_req before a grant withdraws
// the request; changing fields after the grant does not affect the access.
//
// Modports: slave = arbiter view, master = requesters plus memory model view.
interface maze_mem_arbiter_if;
  import maze_mem_arbiter_pkg::*;

  logic [1:0]              rq_req;
  logic [1:0]              rq_lock;
  logic [1:0]              rq_rd;
  logic [1:0]              rq_wr;
  logic [1:0][COORD_W-1:0] rq_x;
  logic [1:0][COORD_W-1:0] rq_y;
  logic [1:0][DATA_W-1:0]  rq_wdata;
  logic [1:0]              rq_ack;
  logic [DATA_W-1:0]       rq_rdata;

  logic [COORD_W-1:0]      mem_x;
  logic [COORD_W-1:0]      mem_y;
  logic                    mem_rd;
  logic                    mem_wr;
  logic [DATA_W-1:0]       mem_din;
  logic [DATA_W-1:0]       mem_dout;

  modport slave (
    input  rq_req, rq_lock, rq_rd, rq_wr, rq_x, rq_y, rq_wdata, mem_dout,
    output rq_ack, rq_rdata, mem_x, mem_y, mem_rd, mem_wr, mem_din
  );

  modport master (
    output rq_req, rq_lock, rq_rd, rq_wr, rq_x, rq_y, rq_wdata, mem_dout,
    input  rq_ack, rq_rdata, mem_x, mem_y, mem_rd, mem_wr, mem_din
  );

endinterface

// File: rtl/maze_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker, purely combinational.
//   req   : request vector
//   last  : port that was served most recently
//   grant : one-hot winner (all zero when nobody requests)
// A lone requester always wins; on a tie the port that was not served last wins.
module maze_mem_arbiter_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Shares the single-port 16x16 maze memory between the solver (port 0) and a
// secondary agent (port 1). Round-robin arbitration with a bounded lock so a
// port can perform an atomic read-modify-write sequence.
//   CLK, RST  : rising-edge clock, synchronous active-high reset
//   bus       : request and memory signals (slave view)
//   owner     : port currently granted, valid while busy=1
//   busy      : high in ACCESS and ACK, and while a lock is held
//   dbg_state : current FSM state
// Timing: request sampled in IDLE cycle T -> memory strobe in T+1 -> ack in T+2,
// so one access completes every three cycles at most.
module maze_mem_arbiter
  import maze_mem_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic              CLK,
  input  logic              RST,
  maze_mem_arbiter_if.slave bus,
  output logic              owner,
  output logic              busy,
  output arb_state_t        dbg_state
);

  // lock_cnt never exceeds MAX_LOCK-1: the access that would reach MAX_LOCK
  // drops the lock instead of counting.
  localparam int CNT_W = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK);

  arb_state_t       state;
  mem_cmd_t         cmd;
  logic             lock_hold;
  logic [CNT_W-1:0] lock_cnt;
  logic             rr_last;

  logic             lock_keep;
  logic             lock_drop;
  logic             arb_last;
  logic [1:0]       arb_grant;
  logic             grant_valid;
  logic             grant_port;
  logic             lock_next;

  // A held lock either re-grants its owner or, if the owner has gone quiet,
  // dissolves and the pointer advances before ordinary arbitration this cycle.
  always_comb begin
    lock_keep = lock_hold & bus.rq_req[owner];
    lock_drop = lock_hold & ~bus.rq_req[owner];
    arb_last  = lock_drop ? ~rr_last : rr_last;
  end

  maze_mem_arbiter_rr_arb2 u_rr (
    .req   (bus.rq_req),
    .last  (arb_last),
    .grant (arb_grant)
  );

  assign grant_valid = lock_keep | (arb_grant != 2'b00);
  assign grant_port  = lock_keep ? owner : arb_grant[1];

  // Lock survives this access only if the counter has room for another one.
  assign lock_next = cmd.lock & ((int'(lock_cnt) + 1) < MAX_LOCK);

  // Address and write data come straight from the command register, so they
  // keep their last values outside ACCESS.
  assign bus.mem_x   = cmd.x;
  assign bus.mem_y   = cmd.y;
  assign bus.mem_din = cmd.wdata;
  assign dbg_state   = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      cmd          <= '0;
      lock_hold    <= 1'b0;
      lock_cnt     <= '0;
      rr_last      <= 1'b1;
      owner        <= 1'b0;
      busy         <= 1'b0;
      bus.mem_rd   <= 1'b0;
      bus.mem_wr   <= 1'b0;
      bus.rq_ack   <= 2'b00;
      bus.rq_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (lock_drop) begin
            lock_hold <= 1'b0;
            lock_cnt  <= '0;
            rr_last   <= ~rr_last;
          end
          if (grant_valid) begin
            owner      <= grant_port;
            cmd        <= '{x:     bus.rq_x[grant_port],
                            y:     bus.rq_y[grant_port],
                            rd:    bus.rq_rd[grant_port],
                            wr:    bus.rq_wr[grant_port],
                            wdata: bus.rq_wdata[grant_port],
                            lock:  bus.rq_lock[grant_port]};
            // A write wins when both strobes are requested.
            bus.mem_wr <= bus.rq_wr[grant_port];
            bus.mem_rd <= bus.rq_rd[grant_port] & ~bus.rq_wr[grant_port];
            busy       <= 1'b1;
            state      <= ACCESS;
          end else begin
            busy <= 1'b0;
          end
        end

        ACCESS: begin
          bus.mem_rd   <= 1'b0;
          bus.mem_wr   <= 1'b0;
          bus.rq_ack   <= port_onehot(owner);
          bus.rq_rdata <= (cmd.rd & ~cmd.wr) ? bus.mem_dout : '0;
          state        <= ACK;
        end

        ACK: begin
          bus.rq_ack   <= 2'b00;
          bus.rq_rdata <= '0;
          rr_last      <= owner;
          lock_hold    <= lock_next;
          lock_cnt     <= lock_next ? (lock_cnt + CNT_W'(1)) : '0;
          busy         <= lock_next;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
module tb_maze_mem_arbiter;
  import maze_mem_arbiter_pkg::*;

  localparam int MAX_LOCK = 8;
  localparam int NC       = 4096;
  localparam int ACK_TO   = 60;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  maze_mem_arbiter_if bus();
  logic       owner;
  logic       busy;
  arb_state_t dbg_state;

  maze_mem_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .owner     (owner),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  logic [1:0]              p_req  = '0;
  logic [1:0]              p_lock = '0;
  logic [1:0]              p_rd   = '0;
  logic [1:0]              p_wr   = '0;
  logic [1:0][COORD_W-1:0] p_x    = '0;
  logic [1:0][COORD_W-1:0] p_y    = '0;
  logic [1:0][DATA_W-1:0]  p_wd   = '0;

  assign bus.rq_req   = p_req;
  assign bus.rq_lock  = p_lock;
  assign bus.rq_rd    = p_rd;
  assign bus.rq_wr    = p_wr;
  assign bus.rq_x     = p_x;
  assign bus.rq_y     = p_y;
  assign bus.rq_wdata = p_wd;

  // ---------------- maze memory (environment) ----------------
  function automatic logic [DATA_W-1:0] init_cell(input int x, input int y);
    if ((x == 3 && y == 5) || (x == 15 && y == 15)) return 1'b1;
    return DATA_W'((x * 3 + y) % 2);
  endfunction

  logic [DATA_W-1:0] phys [16][16];
  bit loaded = 1'b0;
  always @(posedge CLK) begin
    if (!loaded) begin
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++)
          phys[y][x] <= init_cell(x, y);
      loaded <= 1'b1;
    end else if (bus.mem_wr) begin
      phys[bus.mem_y][bus.mem_x] <= bus.mem_din;
    end
  end
  assign bus.mem_dout = phys[bus.mem_y][bus.mem_x];

  // ---------------- counters and check helper ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction timeline: a grant decided at edge e puts the strobe in cycle e,
  // the ack in cycle e+1, and the next decision no earlier than edge e+3.
  bit [1:0]         e_ack   [NC];
  bit [DATA_W-1:0]  e_rdata [NC];
  bit               e_rd    [NC];
  bit               e_wr    [NC];
  bit [COORD_W-1:0] e_x     [NC];
  bit [COORD_W-1:0] e_y     [NC];
  bit [DATA_W-1:0]  e_din   [NC];
  bit               e_busy  [NC];
  bit               e_own   [NC];

  bit [DATA_W-1:0] model_mem [16][16];
  bit started = 1'b0;
  bit m_init  = 1'b0;
  int free_at = 0;
  bit m_hold  = 1'b0;
  int m_cnt   = 0;
  bit m_last  = 1'b1;
  bit m_owner = 1'b0;

  always @(posedge CLK) begin
    int g;
    bit rd, wr, lk;
    bit [COORD_W-1:0] x, y;
    bit [DATA_W-1:0] wd, data;
    cyc = cyc + 1;
    if (!m_init) begin
      for (int yy = 0; yy < 16; yy++)
        for (int xx = 0; xx < 16; xx++)
          model_mem[yy][xx] = init_cell(xx, yy);
      m_init = 1'b1;
    end
    if (RST) begin
      started = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (cyc + k < NC) begin
          e_ack[cyc+k] = '0; e_rd[cyc+k] = 0; e_wr[cyc+k] = 0;
          e_busy[cyc+k] = 0;
        end
      end
      free_at = cyc + 1;
      m_hold = 0; m_cnt = 0; m_last = 1; m_owner = 0;
    end else if (started && cyc >= free_at && cyc + 3 < NC) begin
      g = -1;
      if (m_hold && p_req[m_owner]) begin
        g = int'(m_owner);
      end else begin
        if (m_hold) begin
          m_hold = 0; m_cnt = 0; m_last = ~m_last;
        end
        if (p_req == 2'b11)  g = m_last ? 0 : 1;
        else if (p_req[0])   g = 0;
        else if (p_req[1])   g = 1;
      end
      if (g >= 0) begin
        rd = p_rd[g]; wr = p_wr[g]; lk = p_lock[g];
        x = p_x[g]; y = p_y[g]; wd = p_wd[g];
        data = (rd && !wr) ? model_mem[y][x] : '0;
        if (wr) model_mem[y][x] = wd;
        e_rd[cyc] = rd & ~wr; e_wr[cyc] = wr;
        e_x[cyc] = x; e_y[cyc] = y; e_din[cyc] = wd;
        e_busy[cyc] = 1; e_own[cyc] = g[0];
        e_ack[cyc+1] = g[0] ? 2'b10 : 2'b01;
        e_rdata[cyc+1] = data;
        e_busy[cyc+1] = 1; e_own[cyc+1] = g[0];
        m_last = g[0]; m_owner = g[0];
        if (lk && m_cnt + 1 < MAX_LOCK) begin m_hold = 1; m_cnt++; end
        else begin m_hold = 0; m_cnt = 0; end
        e_busy[cyc+2] = m_hold; e_own[cyc+2] = g[0];
        free_at = cyc + 3;
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare + ack log ----------------
  int ack_port_q[$];
  int ack_cyc_q[$];
  logic [0:0] exp_q[$];

  always @(negedge CLK) begin
    if (started && cyc < NC) begin
      chk("ack", bus.rq_ack, e_ack[cyc]);
      if (e_ack[cyc] != 2'b00) chk("rdata", bus.rq_rdata, e_rdata[cyc]);
      chk("mem_rd", bus.mem_rd, e_rd[cyc]);
      chk("mem_wr", bus.mem_wr, e_wr[cyc]);
      if (e_rd[cyc] || e_wr[cyc]) begin
        chk("mem_x", bus.mem_x, e_x[cyc]);
        chk("mem_y", bus.mem_y, e_y[cyc]);
      end
      if (e_wr[cyc]) chk("mem_din", bus.mem_din, e_din[cyc]);
      chk("busy", busy, e_busy[cyc]);
      if (e_busy[cyc]) chk("owner", owner, e_own[cyc]);
      if (bus.rq_ack != 2'b00) begin
        ack_port_q.push_back(bus.rq_ack[1] ? 1 : 0);
        ack_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic check_order(input string name, input int base);
    chk({name, "_count"}, ack_port_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < ack_port_q.size()) chk(name, ack_port_q[base+i], exp_q[i]);
      else chk({name, "_missing"}, 2, exp_q[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    p_req = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  // Presents one access on port p and waits for its ack; rq_req stays high.
  task automatic do_access(input bit p, input bit lk, input bit rd, input bit wr,
                           input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                           input logic [DATA_W-1:0] wd,
                           output logic [DATA_W-1:0] rdata, output int lat);
    bit got;
    p_lock[p] = lk; p_rd[p] = rd; p_wr[p] = wr;
    p_x[p] = x; p_y[p] = y; p_wd[p] = wd;
    p_req[p] = 1'b1;
    lat = 0; got = 0; rdata = '0;
    while (!got && lat < ACK_TO) begin
      @(negedge CLK);
      lat++;
      if (bus.rq_ack[p]) begin
        got = 1;
        rdata = bus.rq_rdata;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout port %0d: no ack within %0d cycles, ack required", p, lat);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [DATA_W-1:0] r;
    int l, base;

    // 1: single read of preloaded (3,5)
    do_reset();
    do_access(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd5, 1'b0, r, l);
    p_req[0] = 1'b0;
    chk("t1_latency", l, 2);
    chk("t1_rdata", r, 1);

    // 2: two continuous unlocked requesters alternate, acks 3 cycles apart
    do_reset();
    base = ack_port_q.size();
    fork
      begin
        logic [DATA_W-1:0] r0; int l0;
        for (int i = 0; i < 6; i++) do_access(1'b0, 1'b0, 1'b1, 1'b0, COORD_W'(i), 4'd1, 1'b0, r0, l0);
        p_req[0] = 1'b0;
      end
      begin
        logic [DATA_W-1:0] r1; int l1;
        for (int i = 0; i < 6; i++) do_access(1'b1, 1'b0, 1'b1, 1'b0, COORD_W'(i), 4'd9, 1'b0, r1, l1);
        p_req[1] = 1'b0;
      end
    join
    #1;
    exp_q = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    check_order("t2_order", base);
    for (int i = 1; i < 12; i++)
      if (base + i < ack_cyc_q.size()) chk("t2_spacing", ack_cyc_q[base+i] - ack_cyc_q[base+i-1], 3);

    // 3: locked read-modify-write on (2,2) while port 1 waits
    do_reset();
    base = ack_port_q.size();
    fork
      begin
        logic [DATA_W-1:0] r0; int l0;
        do_access(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 4'd2, 1'b0, r0, l0);
        chk("t3_first_read", r0, 0);
        do_access(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 1'b1, r0, l0);
        p_req[0] = 1'b0;
      end
      begin
        logic [DATA_W-1:0] r1; int l1;
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 4'd7, 1'b0, r1, l1);
        p_req[1] = 1'b0;
      end
    join
    #1;
    exp_q = '{0, 0, 1};
    check_order("t3_order", base);
    do_access(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd2, 1'b0, r, l);
    p_req[0] = 1'b0;
    chk("t3_readback", r, 1);

    // 4: port 1 locks for 10 accesses; forced release after the 8th
    do_reset();
    base = ack_port_q.size();
    fork
      begin
        logic [DATA_W-1:0] r1; int l1;
        for (int i = 0; i < 10; i++) do_access(1'b1, 1'b1, 1'b1, 1'b0, COORD_W'(i), 4'd3, 1'b0, r1, l1);
        p_req[1] = 1'b0;
      end
      begin
        logic [DATA_W-1:0] r0; int l0;
        @(negedge CLK);
        do_access(1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 4'd4, 1'b0, r0, l0);
        p_req[0] = 1'b0;
      end
    join
    #1;
    exp_q = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    check_order("t4_order", base);

    // 5: rd and wr both set -> write wins, rdata 0
    do_reset();
    do_access(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 4'd15, 1'b0, r, l);
    p_req[0] = 1'b0;
    chk("t5_rdata", r, 0);
    do_access(1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 4'd15, 1'b0, r, l);
    p_req[0] = 1'b0;
    chk("t5_readback", r, 0);

    // 6: reset during ACCESS drops the access; next tie goes to port 0
    do_reset();
    p_lock[0] = 1'b1; p_rd[0] = 1'b1; p_wr[0] = 1'b0;
    p_x[0] = 4'd1; p_y[0] = 4'd1; p_req[0] = 1'b1;
    @(negedge CLK);
    chk("t6_state_access", dbg_state, ACCESS);
    RST = 1'b1;
    p_req = '0;
    @(negedge CLK);
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_no_ack", bus.rq_ack, 0);
    RST = 1'b0;
    base = ack_port_q.size();
    repeat (3) @(negedge CLK);
    fork
      begin
        logic [DATA_W-1:0] r0; int l0;
        do_access(1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd6, 1'b0, r0, l0);
        p_req[0] = 1'b0;
      end
      begin
        logic [DATA_W-1:0] r1; int l1;
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 4'd8, 1'b0, r1, l1);
        p_req[1] = 1'b0;
      end
    join
    #1;
    exp_q = '{0, 1};
    check_order("t6_order", base);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, completion required");
    $fatal(1, "watchdog");
  end

endmodule
